uart_tx_byte: RTL and testbench

- Byte-level UART serializer for the calculator frame transmit path.
- Sits directly downstream of the message-splitting FSM in transmitter_calc. That FSM presents one ASCII character at a time with a start strobe; this block shifts the character out on txd_pin as 8N1 and signals when it can take the next one.
- Runs on the Arty A7 100 MHz system clock with an internal baud-rate divider.

---
 rtl/uart_tx_byte.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_byte.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte.sv
// Byte-level 8N1 UART serializer with internal baud divider.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_byte #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int N        = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         txd,
  output logic         busy,
  output logic         done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_STOP = CW'(DIV - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [N-1:0]   shift_nx;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  assign shift_nx = shift_q >> 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // the done cycle is the last stop clock; refuse start there
        if (start && !done_q) begin
          state_d = S_START;
          shift_d = data;
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_nx;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            txd_d = shift_nx[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_STOP) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte (DIV=10, N=8).
// Expected line waveform is built bit-by-bit from the frame format.
module tb_uart_tx_byte;

  localparam int CLK_FREQ = 100;
  localparam int BAUD     = 10;
  localparam int N        = 8;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = N + 3;
`else
  localparam int NB = N + 2;
`endif
  localparam int FL = NB * DIV;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] data;
  logic         txd;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;
  logic expq[$];

  always #5 clk = ~clk;

  uart_tx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .N       (N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (data),
    .txd  (txd),
    .busy (busy),
    .done (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // one entry per clock: start, data LSB first, [parity], stop
  function automatic void build(input logic [N-1:0] d);
    logic bits[$];
    expq.delete();
    bits.push_back(1'b0);
    for (int b = 0; b < N; b++) bits.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int c = 0; c < DIV; c++) expq.push_back(bits[k]);
  endfunction

  // ends at the negedge inside the done cycle
  task automatic frame(input logic [N-1:0] d,
                       input int poke,
                       input string tag);
    build(d);
    @(negedge clk);
    chk({tag, "_pre_txd"}, 32'(txd), 32'd1);
    chk({tag, "_pre_busy"}, 32'(busy), 32'd0);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("%s_txd@%0d", tag, i),
          32'(txd), 32'(expq[i]));
      chk($sformatf("%s_busy@%0d", tag, i),
          32'(busy), 32'(i < FL - 1));
      chk($sformatf("%s_done@%0d", tag, i),
          32'(done), 32'(i == FL - 1));
      data  = N'($urandom);
      start = 1'b0;
      if (i == poke) begin
        start = 1'b1;
        data  = 8'hFF;
      end
      if (i < FL - 1) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int bad;
    int pulses;
    logic [N-1:0] rb;

    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    repeat (5) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        bad++;
    end
    chk("idle200", 32'(bad), 32'd0);

    frame(8'h41, -1, "A");
    frame(8'h33, 40, "ign");
    frame(8'h31, -1, "c1");
    frame(8'h32, -1, "c2");
    frame(8'h2B, -1, "plus");

    // start raised in the done cycle must not be taken
    start = 1'b1;
    data  = 8'hA5;
    @(negedge clk);
    chk("donecyc_txd", 32'(txd), 32'd1);
    chk("donecyc_busy", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("donecyc_idle", 32'(busy), 32'd0);

    // mid-frame reset
    start = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (35) @(negedge clk);
    chk("mid_txd", 32'(txd), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_txd", 32'(txd), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < FL + 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || txd !== 1'b1) pulses++;
    end
    chk("abort_quiet", 32'(pulses), 32'd0);

    frame(8'h55, -1, "x55");
    frame(8'h07, -1, "x07");
    frame(8'h03, -1, "x03");

    for (int k = 0; k < 12; k++) begin
      rb = N'($urandom);
      frame(rb, -1, $sformatf("rnd%0d_%02h", k, rb));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
